// File: rtl/round_robin_burst_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_pkg: shared FSM state type and default sizing for the scheduler   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int NUM_REQ_DEF  = 4;
  localparam int HOLD_MAX_DEF = 16;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/round_robin_burst_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | round_robin_burst_scheduler_if: requester-side bundle of the arbiter  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface round_robin_burst_scheduler_if #(
  parameter int NUM_REQ = 4
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_id,
    output busy,
    output timeout
  );

endinterface : round_robin_burst_scheduler_if
`default_nettype wire

// File: rtl/round_robin_burst_scheduler_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick: combinational round-robin winner select (masked + unmasked)  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] req_i,
  input  wire logic [ID_W-1:0]    last_id_i,
  output logic      [NUM_REQ-1:0] pick_o,
  output logic      [ID_W-1:0]    pick_id_o
);

  logic [NUM_REQ-1:0] masked;
  logic               found;

  always_comb begin
    masked    = '0;
    found     = 1'b0;
    pick_id_o = '0;
    pick_o    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = req_i[i] && (i > int'(last_id_i));
    end
    // Requesters above the last winner take precedence; fall back to the wrap-around.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (masked[i] && !found) begin
        pick_id_o = ID_W'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && !found) begin
        pick_id_o = ID_W'(i);
        found     = 1'b1;
      end
    end
    if (found) begin
      pick_o = NUM_REQ'(1) << pick_id_o;
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/round_robin_burst_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | round_robin_burst_scheduler: round-robin owner select, bounded tenure |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module round_robin_burst_scheduler
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  round_robin_burst_scheduler_if.slave   arb
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t             state_q,    state_d;
  logic [NUM_REQ-1:0] grant_q,    grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               busy_q,     busy_d;
  logic               timeout_q,  timeout_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [ID_W-1:0]    last_id_q,  last_id_d;

  logic [NUM_REQ-1:0] pick;
  logic [ID_W-1:0]    pick_id;
  logic               owner_done;
  logic               owner_req;
  logic               at_limit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_i     (arb.req),
    .last_id_i (last_id_q),
    .pick_o    (pick),
    .pick_id_o (pick_id)
  );

  always_comb begin
    owner_done = arb.done[grant_id_q];
    owner_req  = arb.req[grant_id_q];
    at_limit   = (cnt_q == CNT_LAST);

    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;
    last_id_d  = last_id_q;

    unique case (state_q)
      IDLE: begin
        if (arb.req != '0) begin
          state_d    = OWN;
          grant_d    = pick;
          grant_id_d = pick_id;
          busy_d     = 1'b1;
          last_id_d  = pick_id;
          cnt_d      = '0;
        end
      end
      OWN: begin
        if (owner_done || !owner_req || at_limit) begin
          // Timeout only flags a pure limit cut; a coincident done/drop wins.
          state_d   = IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = at_limit && owner_req && !owner_done;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
      last_id_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
      last_id_q  <= last_id_d;
    end
  end

  assign arb.grant    = grant_q;
  assign arb.grant_id = grant_id_q;
  assign arb.busy     = busy_q;
  assign arb.timeout  = timeout_q;

endmodule : round_robin_burst_scheduler
`default_nettype wire
